// File: rtl/hd63701_intc_pkg.sv
// Shared definitions for the HD63701 interrupt controller.
// Holds the sequencer state encodings and the vector address helper.
package hd63701_intc_pkg;

  typedef enum logic [1:0] {
    IC_IDLE  = 2'd0,
    IC_OFFER = 2'd1,
    IC_GAP   = 2'd2
  } ic_state_e;

  // Vector of source idx: base + step*idx, wrapping at 8 bits.
  function automatic logic [7:0] vec_addr(input logic [7:0]  base,
                                          input logic [7:0]  step,
                                          input int unsigned idx);
    logic [31:0] prod;
    prod = 32'(step) * idx;
    return base + prod[7:0];
  endfunction

endpackage

// File: rtl/hd63701_intc_src.sv
// One interrupt source: input sampling, edge/level pending logic and
// acknowledge clearing, with a new edge taking precedence over a clear.
module hd63701_intc_src (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  input  logic mode_i,
  input  logic clr_i,
  output logic pend_o
);

  logic prev_q;
  logic pend_q;
  logic pend_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pend_d = src_i;
    if (mode_i) begin
      pend_d = (src_i & ~prev_q) | (pend_q & ~clr_i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= src_i;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/hd63701_intc.sv
// Interrupt capture and arbitration for the HD63701 sequencer: per-source
// pending latches, fixed priority (highest index wins), registered offer/ack.
module hd63701_intc
  import hd63701_intc_pkg::*;
#(
  parameter int unsigned NSRC   = 4,
  parameter logic [7:0]  VBASE  = 8'hF0,
  parameter logic [7:0]  VSTEP  = 8'd4,
  parameter bit          NMI_EN = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NSRC-1:0]         src_i,
  input  logic [NSRC-1:0]         mode_i,
  input  logic [NSRC-1:0]         mask_i,
  input  logic                    inte_i,
  input  logic                    ack_i,
  output logic                    req_o,
  output logic [7:0]              vec_o,
  output logic [$clog2(NSRC)-1:0] id_o,
  output logic [NSRC-1:0]         pend_o
);

  localparam int IDW = $clog2(NSRC);

  ic_state_e       state_q, state_d;
  logic            req_q, req_d;
  logic [7:0]      vec_q, vec_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] clr;
  logic [IDW-1:0]  win;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    hd63701_intc_src u_src (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .src_i  (src_i[gi]),
      .mode_i (mode_i[gi]),
      .clr_i  (clr[gi]),
      .pend_o (pend[gi])
    );
    // The top source bypasses masking when it is configured as NMI.
    assign elig[gi] = pend[gi] & ((mask_i[gi] & inte_i) | (NMI_EN && (gi == NSRC - 1)));
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (elig[i]) win = IDW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    vec_d   = vec_q;
    id_d    = id_q;
    clr     = '0;
    case (state_q)
      IC_IDLE: begin
        if (|elig) begin
          state_d = IC_OFFER;
          req_d   = 1'b1;
          id_d    = win;
          vec_d   = vec_addr(VBASE, VSTEP, 32'(win));
        end
      end
      IC_OFFER: begin
        // Acknowledge outranks a simultaneous withdrawal; no preemption here.
        if (ack_i) begin
          clr[id_q] = 1'b1;
          req_d     = 1'b0;
          state_d   = IC_GAP;
        end else if (!elig[id_q]) begin
          req_d   = 1'b0;
          state_d = IC_IDLE;
        end
      end
      IC_GAP: begin
        state_d = IC_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IC_IDLE;
      req_q   <= 1'b0;
      vec_q   <= 8'h00;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      vec_q   <= vec_d;
      id_q    <= id_d;
    end
  end

  assign req_o  = req_q;
  assign vec_o  = vec_q;
  assign id_o   = id_q;
  assign pend_o = pend;

endmodule

// File: doc/hd63701_intc.md
# hd63701_intc

Parametrised interrupt capture and arbitration unit for the HD63701 core, generalising the fixed four-source (NMI/IRQ/IRQ2/IRQ0) latch-and-priority logic of the sequencer. It supports any number of sources, with per-source edge or level mode, per-source masks and an optional non-maskable top source. A registered request/vector/acknowledge handshake lets the sequencer take an interrupt at its instruction boundary. It sits between peripheral interrupt lines and the sequencer's interrupt entry.

## Interface
Parameters:
- NSRC, 4: number of sources; index NSRC-1 has the highest priority.
- VBASE, 8'hF0: vector address of source 0.
- VSTEP, 4: vector spacing. Source i vector = VBASE + VSTEP*i, modulo 256. With defaults the vectors are F0/F4/F8/FC.
- NMI_EN, 1: when 1, source NSRC-1 ignores MASK and INTE.

Ports:
- CLK in 1: clock; all state on posedge.
- RST in 1: reset; synchronous, active-high.
- SRC in NSRC: raw interrupt lines, synchronous to CLK.
- MODE in NSRC: per source, 1 = rising-edge latched, 0 = level.
- MASK in NSRC: per source, 1 = enabled.
- INTE in 1: global enable (the inverse of the CPU I flag).
- ACK in 1: sequencer takes the offered interrupt; single-cycle pulse.
- REQ out 1: interrupt offered.
- VEC out 8: vector address of the offered source.
- ID out $clog2(NSRC): index of the offered source.
- PEND out NSRC: raw pending bits, for status reads.

## Operation
- Per source: prev register holds last SRC sample. Edge mode: pending bit set when SRC & ~prev, cleared when that source is acknowledged. Level mode: pending = registered SRC; ACK has no clearing effect.
- Set/clear collision: a new edge on the same cycle as the ACK of that source leaves the bit set (set wins).
- Eligible(i) = PEND[i] & ((MASK[i] & INTE) | (NMI_EN & i==NSRC-1)).
- Winner: highest-index eligible source.
- FSM states: IDLE, OFFER, GAP.
  - IDLE: if any source is eligible, latch winner into ID/VEC, REQ=1, go to OFFER.
  - OFFER: ID/VEC frozen; a higher-priority source arriving does not preempt.
    - ACK: clear the edge pending bit of ID, REQ=0, go to GAP.
    - No ACK and source ID no longer eligible (level dropped, mask or INTE removed): REQ=0, go to IDLE.
    - ACK and withdrawal in the same cycle: ACK is honoured.
  - GAP: one cycle with REQ=0, then go to IDLE and re-arbitrate.
- ACK while REQ=0: ignored.
- RST mid-operation: all pending bits and any offer are discarded.

## Timing
- Reset values: REQ=0, VEC=0, ID=0, PEND=0, prev=0, state=IDLE.
- Prev resets to 0, so a line held high through reset registers an edge on the first clock after reset.
- Latency: SRC rising at edge k -> PEND set at k+1 -> REQ/VEC valid at k+2.
- After ACK at edge k: REQ=0 at k+1 (GAP), next REQ no earlier than k+2.
- Back-to-back pending sources are offered at most every 2 cycles.
- Withdrawal: REQ drops one cycle after eligibility is lost.
- Outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared include HD63701_defs.i gains:
  - state encodings icIDLE/icOFFER/icGAP;
  - a vector-compute function (VBASE + VSTEP*i, 8-bit wrap).
- Sub-module hd63701_intc_src: one per source, built with generate. It holds prev, pending, the edge/level mux and the clear/set-priority logic; inputs are SRC, MODE and clr, output is PEND.
- Priority encoder and FSM live in the top level.

## Test plan
- NSRC=4, MODE=4'hF, MASK=4'hF, INTE=1. Pulse SRC[1] one cycle -> REQ at +2, VEC=F4, ID=1. ACK -> REQ=0 next cycle, PEND[1]=0.
- SRC[0] and SRC[3] rise together -> VEC=FC offered first. ACK -> GAP one cycle -> VEC=F0 offered.
- INTE=0, MASK=0, edge on SRC[3] with NMI_EN=1 -> REQ=1, VEC=FC. Same with NMI_EN=0 -> REQ stays 0, PEND[3]=1.
- Level source 2 (MODE[2]=0) held high, then dropped while in OFFER without ACK -> REQ=0 one cycle later, state IDLE. Repeat with ACK in the drop cycle -> ACK honoured, GAP entered.
- Edge on SRC[1] in the same cycle ACK clears ID=1 -> PEND[1] remains 1, re-offered after GAP. Separately, ACK with REQ=0 -> no state change.
- RST asserted during OFFER -> all outputs 0 next cycle. SRC held high through RST release -> REQ at +2 after release.
